uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit (16x oversampled rate, matching the receiver).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port TX_Data  input  8  byte to transmit; sampled on accept.
REQ-005 SHALL have port TX_Valid  input  1  byte offered on TX_Data.
REQ-006 SHALL have port TX_Ready  output  1  holding register empty; accept when TX_Valid && TX_Ready.
REQ-007 SHALL have port TXD  output  1  serial line, registered, idle high.
REQ-008 SHALL have port TX_Busy  output  1  high while FSM not in IDLE.
REQ-009 SHALL have port TX_Done  output  1  one-cycle pulse on completion of each frame's stop bit.

Function
REQ-010 SHALL frame as: start bit 0, 8 data bits LSB first, parity bit (when enabled), 1 stop bit of 1.
REQ-011 SHALL compute parity as XOR of the 8 data bits (even parity; 1 when data has an odd number of ones).
REQ-012 SHALL hold each bit on TXD for exactly CLKS_PER_BIT cycles, timed by a bit counter 0..CLKS_PER_BIT-1 that wraps to 0.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with a 3-bit data bit index 0..7.
REQ-014 SHALL transition: IDLE->START when holding register full; START->DATA, DATA(index 7)->PARITY, PARITY->STOP, each on bit counter wrap.
REQ-015 SHALL, at STOP counter wrap, pulse TX_Done and go to START if holding register full, else IDLE.
REQ-016 SHALL provide a one-entry holding register; TX_Ready = not full (from registered state, no combinational path from TX_Valid).
REQ-017 SHALL move holding register into the shift register and mark it empty on the cycle the FSM enters START.
REQ-018 SHALL, with FSM idle and holding empty, drive TXD low (start bit) starting 2 rising edges after the accept edge.
REQ-019 SHALL send back-to-back frames with no idle cycles between stop bit and next start bit when the holding register is full at stop end.
REQ-020 SHALL ignore TX_Data and TX_Valid while TX_Ready is low; a pending byte is never overwritten.
REQ-021 SHALL keep TXD high in IDLE and in STOP.

Reset
REQ-022 SHALL, while reset is high at a rising edge, set state IDLE, counters 0, holding empty, TXD=1, TX_Ready=1, TX_Busy=0, TX_Done=0.
REQ-023 SHALL abort any frame in progress on reset; TXD returns high on the next edge and the pending byte is discarded.
REQ-024 SHALL not accept a byte in the cycle reset is asserted.

Configuration
REQ-025 SHALL use macro UART_TX_PARITY_EN: when defined, the PARITY state and bit are sent (11-bit frame, 11*CLKS_PER_BIT cycles).
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state; DATA(index 7) goes directly to STOP (10-bit frame).

Verification
REQ-027 SHALL verify: accept 0xA5 from idle, parity on -> TXD 0,1,0,1,0,0,1,0,1,0(parity),1 each 16 cycles; TX_Done once at cycle 176 of the frame.
REQ-028 SHALL verify: 0x07 with parity on -> parity bit 1; with UART_TX_PARITY_EN undefined -> no parity bit, stop bit after bit 7, frame 160 cycles.
REQ-029 SHALL verify: TX_Valid held high with 0x11 then 0x22 -> second accepted during first frame's START, TX_Ready low until first frame's START entry, frames contiguous with no idle cycle.
REQ-030 SHALL verify: reset asserted at cycle 50 of a 0xFF frame -> TXD=1, TX_Busy=0, TX_Ready=1 next edge; no TX_Done.
REQ-031 SHALL verify: loopback TXD into the team's receiver with 0x3C -> RX_Data=0x3C, Valid_rx=1, Parity_error=0, Stop_error=0.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter with one-entry holding register; define UART_TX_PARITY_EN to add an even parity bit
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TX_Data,
    input  logic       TX_Valid,
    output logic       TX_Ready,
    output logic       TXD,
    output logic       TX_Busy,
    output logic       TX_Done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_hold, r_shift;
    logic          r_full, r_txd, r_done;
    logic          w_wrap, w_load, w_start, w_txd;
    assign w_wrap   = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_load   = TX_Valid && !r_full;
    assign w_start  = (w_state_nxt == START) && (r_state != START);
    assign w_txd    = (r_state == START) ? 1'b0 :
                      (r_state == DATA) ? r_shift[r_idx] :
                      (r_state == PARITY) ? ^r_shift : 1'b1;
    assign TX_Ready = !r_full;
    assign TXD      = r_txd;
    assign TX_Busy  = r_state != IDLE;
    assign TX_Done  = r_done;
    // frame sequencing; a full holding register at stop end chains straight into the next start bit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = r_full ? START : IDLE;
            START:   w_state_nxt = w_wrap ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:    w_state_nxt = (w_wrap && r_idx == 3'd7) ? PARITY : DATA;
            PARITY:  w_state_nxt = w_wrap ? STOP : PARITY;
`else
            DATA:    w_state_nxt = (w_wrap && r_idx == 3'd7) ? STOP : DATA;
`endif
            STOP:    w_state_nxt = w_wrap ? (r_full ? START : IDLE) : STOP;
            default: w_state_nxt = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end
    // bit timing, holding/shift registers and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
            r_txd  <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= (r_state == IDLE || w_wrap) ? '0 : r_cnt + 1'b1;
            r_idx  <= (r_state == DATA && w_wrap) ? r_idx + 3'd1 : r_idx;
            r_full <= w_load ? 1'b1 : (w_start ? 1'b0 : r_full);
            r_txd  <= w_txd;
            r_done <= (r_state == STOP) && w_wrap;
        end
        r_hold  <= (w_load && !reset) ? TX_Data : r_hold;
        r_shift <= w_start ? r_hold : r_shift;
    end
endmodule
